// File: rtl/bpb_updater.sv
// bpb_updater: write-side controller for the branch prediction buffer.
// Detects mispredictions on resolved branches, issues a one-cycle fetch
// redirect, queues allocate/train records in a show-ahead FIFO and drains
// them one per cycle into the BPB entry write port. Keeps branch statistics.
module bpb_updater #(
  parameter int ENTRIES    = 16,
  parameter int TAG_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int IDX       = $clog2(ENTRIES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [31:0]          res_pc,
  input  logic                 res_taken,
  input  logic [31:0]          res_target,
  input  logic                 res_hit,
  input  logic                 res_pred_taken,
  input  logic [31:0]          res_pred_target,
  output logic                 redirect,
  output logic [31:0]          redirect_pc,
  output logic                 upd_valid,
  input  logic                 upd_ready,
  output logic                 upd_alloc,
  output logic                 upd_train,
  output logic [IDX-1:0]       upd_index,
  output logic [TAG_WIDTH-1:0] upd_tag,
  output logic [31:0]          upd_addr,
  output logic                 upd_taken,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

  typedef struct packed {
    logic                 alloc;
    logic                 train;
    logic                 taken;
    logic [IDX-1:0]       index;
    logic [TAG_WIDTH-1:0] tag;
    logic [31:0]          addr;
  } rec_t;

  rec_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          redirect_q, redirect_d;
  logic [31:0]   redirect_pc_q, redirect_pc_d;
  logic [31:0]   br_cnt_q, br_cnt_d;
  logic [31:0]   mis_cnt_q, mis_cnt_d;

  logic accept, pred_eff, tgt_mismatch, mispredict, push, pop, empty, full;
  rec_t new_rec;
  rec_t head;

  // Resolution decode: mispredict detection and record classification.
  always_comb begin
    full         = (count_q == DEPTH_C);
    empty        = (count_q == '0);
    accept       = res_valid & ~full;
    pred_eff     = res_hit & res_pred_taken;
    tgt_mismatch = (res_target != res_pred_target);
    mispredict   = (res_taken != pred_eff) | (res_taken & pred_eff & tgt_mismatch);
    new_rec       = '0;
    new_rec.index = res_pc[IDX+1:2];
    new_rec.tag   = res_pc[IDX+TAG_WIDTH+1:IDX+2];
    new_rec.addr  = res_target;
    new_rec.taken = res_taken;
    push          = 1'b0;
    if (res_hit && res_taken && tgt_mismatch) begin
      // Stale target on a hit: reload the entry rather than train it.
      new_rec.alloc = 1'b1;
      push          = accept;
    end else if (res_hit) begin
      new_rec.train = 1'b1;
      push          = accept;
    end else if (res_taken) begin
      new_rec.alloc = 1'b1;
      push          = accept;
    end
    pop = ~empty & upd_ready;
  end

  // Next-state for queue pointers, redirect and statistics.
  always_comb begin
    wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d       = count_q;
    if (push && !pop) begin
      count_d = count_q + (PW+1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (PW+1)'(1);
    end
    redirect_d    = accept & mispredict;
    redirect_pc_d = redirect_pc_q;
    if (accept && mispredict) begin
      redirect_pc_d = res_taken ? res_target : res_pc + 32'd4;
    end
    br_cnt_d  = accept ? br_cnt_q + 32'd1 : br_cnt_q;
    mis_cnt_d = (accept && mispredict) ? mis_cnt_q + 32'd1 : mis_cnt_q;
  end

  // State registers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      br_cnt_q      <= '0;
      mis_cnt_q     <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= new_rec;
      end
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      br_cnt_q      <= br_cnt_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  // Output mapping: show-ahead head of the queue and registered status.
  always_comb begin
    head             = mem_q[rd_ptr_q];
    res_ready        = ~full;
    redirect         = redirect_q;
    redirect_pc      = redirect_pc_q;
    upd_valid        = ~empty;
    upd_alloc        = head.alloc;
    upd_train        = head.train;
    upd_taken        = head.taken;
    upd_index        = head.index;
    upd_tag          = head.tag;
    upd_addr         = head.addr;
    stat_branches    = br_cnt_q;
    stat_mispredicts = mis_cnt_q;
  end

endmodule

// File: tb/tb_bpb_updater.sv
// Testbench for bpb_updater: table of single resolutions plus hand-written
// sequences for backpressure, back-to-back redirects and mid-run reset.
module tb_bpb_updater;

  logic        clk = 1'b0;
  logic        reset;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_hit;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic        upd_ready;
  logic        upd_alloc;
  logic        upd_train;
  logic [3:0]  upd_index;
  logic [7:0]  upd_tag;
  logic [31:0] upd_addr;
  logic        upd_taken;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int n_checks = 0;
  int n_errors = 0;
  int exp_br   = 0;
  int exp_mis  = 0;

  bpb_updater #(.ENTRIES(16), .TAG_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
    .res_taken(res_taken), .res_target(res_target), .res_hit(res_hit),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_alloc(upd_alloc),
    .upd_train(upd_train), .upd_index(upd_index), .upd_tag(upd_tag),
    .upd_addr(upd_addr), .upd_taken(upd_taken),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic        pt;
    logic        tk;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] ptgt;
    logic        mis;
    logic [31:0] rpc;
    logic        push;
    logic        alloc;
    logic        train;
    logic        utk;
    logic [3:0]  idx;
    logic [7:0]  tag;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic hit, input logic pt, input logic tk,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input logic [31:0] ptgt);
    res_hit         = hit;
    res_pred_taken  = pt;
    res_taken       = tk;
    res_pc          = pc;
    res_target      = tgt;
    res_pred_target = ptgt;
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, " stat_branches"}, stat_branches, exp_br);
    chk({tag, " stat_mispredicts"}, stat_mispredicts, exp_mis);
  endtask

  initial begin
    //          hit  pt   tk   pc            tgt           ptgt          mis  rpc           push alloc train utk idx   tag
    vecs[0] = '{1'b0,1'b0,1'b1,32'h0000_0100,32'h0000_0200,32'h0000_0000,1'b1,32'h0000_0200,1'b1,1'b1,1'b0,1'b1,4'h0,8'h04};
    vecs[1] = '{1'b1,1'b1,1'b1,32'h0000_0120,32'h0000_0400,32'h0000_0400,1'b0,32'h0000_0000,1'b1,1'b0,1'b1,1'b1,4'h8,8'h04};
    vecs[2] = '{1'b1,1'b1,1'b0,32'h0000_03FC,32'h0000_1234,32'h0000_1234,1'b1,32'h0000_0400,1'b1,1'b0,1'b1,1'b0,4'hF,8'h0F};
    vecs[3] = '{1'b0,1'b0,1'b0,32'h0000_0500,32'h0000_0000,32'h0000_0000,1'b0,32'h0000_0000,1'b0,1'b0,1'b0,1'b0,4'h0,8'h00};
    vecs[4] = '{1'b1,1'b1,1'b1,32'h0000_0044,32'h0000_0800,32'h0000_0900,1'b1,32'h0000_0800,1'b1,1'b1,1'b0,1'b1,4'h1,8'h01};
    vecs[5] = '{1'b1,1'b0,1'b1,32'h0000_0010,32'h0000_0600,32'h0000_0600,1'b1,32'h0000_0600,1'b1,1'b0,1'b1,1'b1,4'h4,8'h00};
    vecs[6] = '{1'b1,1'b1,1'b0,32'hFFFF_FFFC,32'h0000_0000,32'h0000_0040,1'b1,32'h0000_0000,1'b1,1'b0,1'b1,1'b0,4'hF,8'hFF};
    vecs[7] = '{1'b1,1'b0,1'b0,32'h0000_02A8,32'h0000_1000,32'h0000_2000,1'b0,32'h0000_0000,1'b1,1'b0,1'b1,1'b0,4'hA,8'h0A};
    vecs[8] = '{1'b0,1'b1,1'b1,32'h0000_ABC0,32'h0000_7770,32'h0000_7770,1'b1,32'h0000_7770,1'b1,1'b1,1'b0,1'b1,4'h0,8'hAF};
    vecs[9] = '{1'b0,1'b1,1'b0,32'h0000_0030,32'h0000_0000,32'h0000_0000,1'b0,32'h0000_0000,1'b0,1'b0,1'b0,1'b0,4'h0,8'h00};

    reset     = 1'b1;
    res_valid = 1'b0;
    upd_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst redirect", {31'b0, redirect}, 32'd0);
    chk("rst redirect_pc", redirect_pc, 32'd0);
    chk("rst upd_valid", {31'b0, upd_valid}, 32'd0);
    chk("rst res_ready", {31'b0, res_ready}, 32'd1);
    chk("rst upd_alloc", {31'b0, upd_alloc}, 32'd0);
    chk("rst upd_addr", upd_addr, 32'd0);
    chk_stats("rst");
    @(negedge clk);
    reset = 1'b0;

    // Single resolutions, queue drained between each.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].hit, vecs[i].pt, vecs[i].tk, vecs[i].pc, vecs[i].tgt, vecs[i].ptgt);
      res_valid = 1'b1;
      @(posedge clk);
      #1;
      res_valid = 1'b0;
      exp_br++;
      if (vecs[i].mis) exp_mis++;
      chk($sformatf("v%0d redirect", i), {31'b0, redirect}, {31'b0, vecs[i].mis});
      if (vecs[i].mis) chk($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].rpc);
      chk($sformatf("v%0d upd_valid", i), {31'b0, upd_valid}, {31'b0, vecs[i].push});
      if (vecs[i].push) begin
        chk($sformatf("v%0d upd_alloc", i), {31'b0, upd_alloc}, {31'b0, vecs[i].alloc});
        chk($sformatf("v%0d upd_train", i), {31'b0, upd_train}, {31'b0, vecs[i].train});
        chk($sformatf("v%0d upd_index", i), {28'b0, upd_index}, {28'b0, vecs[i].idx});
        chk($sformatf("v%0d upd_tag", i), {24'b0, upd_tag}, {24'b0, vecs[i].tag});
        if (vecs[i].train) chk($sformatf("v%0d upd_taken", i), {31'b0, upd_taken}, {31'b0, vecs[i].utk});
        if (vecs[i].alloc) chk($sformatf("v%0d upd_addr", i), upd_addr, vecs[i].tgt);
      end
      chk_stats($sformatf("v%0d", i));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d redirect off", i), {31'b0, redirect}, 32'd0);
      chk($sformatf("v%0d drained", i), {31'b0, upd_valid}, 32'd0);
    end

    // Back-to-back mispredicts with simultaneous push and pop.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_A000, 32'h0);
    res_valid = 1'b1;
    @(posedge clk);
    #1;
    exp_br++; exp_mis++;
    chk("b2b first redirect", {31'b0, redirect}, 32'd1);
    chk("b2b first head", upd_addr, 32'h0000_A000);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_2000, 32'h0000_B000, 32'h0);
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    exp_br++; exp_mis++;
    chk("b2b second redirect", {31'b0, redirect}, 32'd1);
    chk("b2b second redirect_pc", redirect_pc, 32'h0000_B000);
    chk("b2b second valid", {31'b0, upd_valid}, 32'd1);
    chk("b2b second head", upd_addr, 32'h0000_B000);
    @(posedge clk);
    #1;
    chk("b2b drained", {31'b0, upd_valid}, 32'd0);
    chk_stats("b2b");

    // Backpressure: fill the queue, then drain in order.
    @(negedge clk);
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h0000_0100 + 32'(i * 4), 32'h0001_0000 + 32'(i * 16), 32'h0);
      res_valid = 1'b1;
      @(posedge clk);
      #1;
      exp_br++; exp_mis++;
      chk($sformatf("fill%0d redirect", i), {31'b0, redirect}, 32'd1);
      chk($sformatf("fill%0d redirect_pc", i), redirect_pc, 32'h0001_0000 + 32'(i * 16));
      chk($sformatf("fill%0d head stable", i), upd_addr, 32'h0001_0000);
      chk($sformatf("fill%0d res_ready", i), {31'b0, res_ready}, (i == 3) ? 32'd0 : 32'd1);
      @(negedge clk);
    end
    // Full with a pop in the same cycle: the offered resolution is refused.
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0009_9990, 32'h0);
    upd_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("full no redirect", {31'b0, redirect}, 32'd0);
    chk("full res_ready after pop", {31'b0, res_ready}, 32'd1);
    chk("drain head1", upd_addr, 32'h0001_0010);
    chk_stats("full");
    @(negedge clk);
    res_valid = 1'b0;
    for (int i = 2; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("drain head%0d", i), upd_addr, 32'h0001_0000 + 32'(i * 16));
      chk($sformatf("drain idx%0d", i), {28'b0, upd_index}, 32'(i + 0));
    end
    @(posedge clk);
    #1;
    chk("drain empty", {31'b0, upd_valid}, 32'd0);

    // Reset mid-operation drops records and a pending redirect.
    @(negedge clk);
    upd_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_C000, 32'h0);
    res_valid = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0304, 32'h0000_C000, 32'h0000_C000);
    @(negedge clk);
    res_valid = 1'b0;
    chk("pre-reset redirect", {31'b0, redirect}, 32'd1);
    chk("pre-reset valid", {31'b0, upd_valid}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_br  = 0;
    exp_mis = 0;
    chk("post-reset redirect", {31'b0, redirect}, 32'd0);
    chk("post-reset upd_valid", {31'b0, upd_valid}, 32'd0);
    chk("post-reset res_ready", {31'b0, res_ready}, 32'd1);
    chk_stats("post-reset");
    @(negedge clk);
    reset     = 1'b0;
    upd_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("after reset idle", {31'b0, upd_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
